if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage that owns the PC and drives the IF/ID register: IF_PC_4, IF_Instruct, IF_ID_Write, IF_ID_Flush.
- Fetches from an instruction memory that may insert wait states.
- Selects the next PC from sequential, branch, jump, register, illegal-op and exception/interrupt sources.
- Latches external interrupts and takes them only in user mode (PC[31]=0).

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- ILLOP_ADDR, 32'h80000004, target for pc_sel=4.
- XADR_ADDR, 32'h80000008, target for pc_sel=5, interrupts and fetch timeout.
- WAIT_W, 4, width of the fetch wait counter.
- MAX_WAIT, 15, number of consecutive not-ready cycles that triggers a timeout (must be < 2^WAIT_W).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- PCWrite  input  1  1 = PC may advance; 0 = load-use stall from the hazard unit.
- pc_sel  input  3  0 PC+4, 1 branch, 2 jump, 3 register, 4 ILLOP, 5 XADR, 6/7 treated as 0.
- branch_target  input  32  resolved branch target (ConBA).
- jump_target  input  32  J/JAL target.
- jr_target  input  32  JR/JALR register value.
- irq  input  1  external interrupt request, level.
- imem_addr  output  32  fetch address (= PC).
- imem_rdata  input  32  instruction word.
- imem_ready  input  1  imem_rdata is valid for imem_addr this cycle.
- IF_PC_4  output  32  {PC[31], PC[30:0]+4}.
- IF_Instruct  output  32  imem_rdata when a fetch completes, else 0.
- IF_ID_Write  output  1  IF/ID capture enable.
- IF_ID_Flush  output  1  IF/ID bubble insert.
- irq_take  output  1  one-cycle pulse when an interrupt is taken.
- irq_epc  output  32  PC of the squashed instruction, registered at irq_take.

Behaviour:
- Reset (asynchronous, reset low):
  - PC=RESET_PC, state=FETCH, wait_cnt=0, irq_pending=0, irq_take=0, irq_epc=0.
  - Outputs while in reset: IF_ID_Write=0, IF_ID_Flush=1.
- States:
  - FETCH: first cycle of an access.
  - WAIT: imem not yet ready.
  - imem_addr=PC in both states.
- Next-PC arithmetic:
  - PC+4 wraps within bits [30:0]; bit 31 is preserved.
  - Codes 1 and 2 force target bit31 = current PC[31].
  - Code 3 loads all 32 bits.
  - Codes 4 and 5 load their parameter values, which carry bit31=1.
- Per-cycle priority, first match wins:
  1. Redirect (pc_sel≠0, any state, regardless of PCWrite or ready):
     - PC<=target, IF_ID_Flush=1, state<=FETCH, wait_cnt<=0.
     - An outstanding fetch is abandoned.
  2. Interrupt (irq_pending=1, PC[31]=0, PCWrite=1):
     - PC<=XADR_ADDR, irq_epc<=PC, irq_take<=1, irq_pending<=0, IF_ID_Flush=1, state<=FETCH.
  3. Stall (PCWrite=0):
     - PC holds, IF_ID_Write=0, IF_ID_Flush=0, state and wait_cnt hold.
  4. Not ready (imem_ready=0):
     - PC holds, IF_ID_Flush=1 (NOP injected), state<=WAIT, wait_cnt<=wait_cnt+1.
     - If wait_cnt==MAX_WAIT-1: PC<=XADR_ADDR, state<=FETCH, wait_cnt<=0.
  5. Normal (imem_ready=1):
     - IF_ID_Write=1, IF_ID_Flush=0, IF_Instruct=imem_rdata, PC<=PC+4, state<=FETCH, wait_cnt<=0.
- Output values outside the normal case:
  - IF_Instruct=0 whenever step 5 does not apply.
  - IF_ID_Write=0 whenever IF_ID_Flush=1.
- Fetch latency: 1 cycle with zero wait states, +1 cycle per not-ready cycle.
- Interrupt latch:
  - irq_pending is set on an irq rising edge (edge register of the previous irq).
  - It stays set until the interrupt is taken; further edges while pending are merged.
  - In kernel mode (PC[31]=1) it is held and taken after return to user mode.
- irq_take deasserts the cycle after it pulses.
- irq_epc holds its value until the next interrupt is taken.
- Reset mid-WAIT: the access is abandoned and the stage restarts from RESET_PC.

Optional Feature:
- IRQ_SYNC_EN defined:
  - irq passes through a two-flop synchronizer (reset to 0) before edge detection.
  - Adds 2 cycles from irq rise to irq_pending.
- IRQ_SYNC_EN not defined:
  - irq is assumed synchronous to clk.
  - irq_pending is set on the first rising edge of clk that sees irq high after a low sample.

Test Plan:
- Reset release, imem_ready=1, rdata=0x11111111 → first IF_PC_4=0x80000004; imem_addr sequence 0x80000000, 0x80000004, 0x80000008; IF_ID_Write=1.
- imem_ready low 3 cycles at PC=0x00400000 → IF_ID_Flush=1 for 3 cycles, PC holds, then one capture with IF_PC_4=0x00400004.
- imem_ready held low → after MAX_WAIT=15 cycles PC=0x80000008, wait_cnt=0.
- PC=0x00400010, irq pulse → irq_take=1 one cycle, irq_epc=0x00400010, next imem_addr=0x80000008, IF_ID_Flush=1.
- PC=0x80000020, irq pulse → no irq_take; after a jr_target=0x00400100 redirect (pc_sel=3), interrupt taken with irq_epc=0x00400100.
- In WAIT, pc_sel=1, branch_target=0x80400200, PC[31]=0 → next PC=0x00400200, flush, state FETCH; PCWrite=0 alone → PC and IF/ID hold.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, handles imem wait states with a timeout, and drives the IF/ID register.
// Optional macro IRQ_SYNC_EN adds a two-flop synchronizer on irq ahead of edge detection.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h80000000,
  parameter logic [31:0] ILLOP_ADDR = 32'h80000004,
  parameter logic [31:0] XADR_ADDR  = 32'h80000008,
  parameter int          WAIT_W     = 4,
  parameter int          MAX_WAIT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] IF_PC_4,
  output logic [31:0] IF_Instruct,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        irq_take,
  output logic [31:0] irq_epc
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_WAIT  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                irq_pending_q, irq_pending_d;
  logic                irq_prev_q;
  logic                irq_take_q, irq_take_d;
  logic [31:0]         irq_epc_q, irq_epc_d;

  logic                irq_s;
  logic                irq_edge;
  logic                redirect;
  logic [31:0]         redirect_pc;
  logic [31:0]         pc_plus4;
  logic                flush_c;
  logic                write_c;
  logic [31:0]         instr_c;

  // Branch/jump targets only supply the low 31 bits; the mode bit comes from the PC.
  logic                unused_target_msbs;
  assign unused_target_msbs = branch_target[31] ^ jump_target[31];

`ifdef IRQ_SYNC_EN
  logic [1:0] irq_sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_sync_q <= 2'b00;
    end else begin
      irq_sync_q <= {irq_sync_q[0], irq};
    end
  end

  assign irq_s = irq_sync_q[1];
`else
  assign irq_s = irq;
`endif

  assign irq_edge = irq_s & ~irq_prev_q;

  always_comb begin
    pc_plus4    = {pc_q[31], pc_q[30:0] + 31'd4};
    redirect    = 1'b1;
    redirect_pc = pc_q;
    case (pc_sel)
      3'd1:    redirect_pc = {pc_q[31], branch_target[30:0]};
      3'd2:    redirect_pc = {pc_q[31], jump_target[30:0]};
      3'd3:    redirect_pc = jr_target;
      3'd4:    redirect_pc = ILLOP_ADDR;
      3'd5:    redirect_pc = XADR_ADDR;
      default: redirect    = 1'b0;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    irq_pending_d = irq_pending_q | irq_edge;
    irq_take_d    = 1'b0;
    irq_epc_d     = irq_epc_q;
    flush_c       = 1'b0;
    write_c       = 1'b0;
    instr_c       = 32'd0;

    if (redirect) begin
      pc_d       = redirect_pc;
      flush_c    = 1'b1;
      state_d    = ST_FETCH;
      wait_cnt_d = '0;
    end else if (irq_pending_q && !pc_q[31] && PCWrite) begin
      pc_d          = XADR_ADDR;
      irq_epc_d     = pc_q;
      irq_take_d    = 1'b1;
      irq_pending_d = 1'b0;
      flush_c       = 1'b1;
      state_d       = ST_FETCH;
      wait_cnt_d    = '0;
    end else if (!PCWrite) begin
      // Load-use stall: everything holds, IF/ID keeps its contents.
    end else if (!imem_ready) begin
      flush_c = 1'b1;
      if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
        pc_d       = XADR_ADDR;
        state_d    = ST_FETCH;
        wait_cnt_d = '0;
      end else begin
        state_d    = ST_WAIT;
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end else begin
      write_c    = 1'b1;
      instr_c    = imem_rdata;
      pc_d       = pc_plus4;
      state_d    = ST_FETCH;
      wait_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      state_q       <= ST_FETCH;
      wait_cnt_q    <= '0;
      irq_pending_q <= 1'b0;
      irq_prev_q    <= 1'b0;
      irq_take_q    <= 1'b0;
      irq_epc_q     <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      irq_pending_q <= irq_pending_d;
      irq_prev_q    <= irq_s;
      irq_take_q    <= irq_take_d;
      irq_epc_q     <= irq_epc_d;
    end
  end

  // While reset is held the IF/ID register is forced to a bubble.
  assign imem_addr   = pc_q;
  assign IF_PC_4     = pc_plus4;
  assign IF_Instruct = reset ? instr_c : 32'd0;
  assign IF_ID_Write = reset & write_c;
  assign IF_ID_Flush = ~reset | flush_c;
  assign irq_take    = irq_take_q;
  assign irq_epc     = irq_epc_q;

endmodule
